// File: rtl/donut_query_sched.sv
// ---------------------------------------------------------------------------
// donut_query_sched
//
// Shares LANES fixed-latency donuthit engines among a stream of per-pixel
// queries. Queries are issued to lanes in round-robin order. Each engine
// result is captured ENGINE_LAT cycles after its start pulse. Results are
// returned in the same round-robin order, so they leave in accept order.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. The producer holds valid and its payload stable until the
// transfer. q_ready depends only on registered lane state and flush.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             synchronous abort of all queries
//   q_valid/q_ready   query handshake; q_tag travels with the query
//   lane_start        one-hot engine start pulse (combinational)
//   eng_hit/eng_luma  per-lane engine results (lane i at [i*LUMA_W +: LUMA_W])
//   r_valid/r_ready   result handshake; r_hit, r_luma, r_tag
//   busy              some lane is not IDLE
//   dbg_lane_state    lane i state at [2*i +: 2] (0 IDLE, 1 BUSY, 2 DONE)
//
// Optional feature (macro DONUT_SCHED_STATS_EN):
//   stat_stall        saturating count of cycles with q_valid && !q_ready
//   stat_hits         wrapping count of retired results with r_hit set
// ---------------------------------------------------------------------------
module donut_query_sched #(
    parameter int LANES      = 2,
    parameter int ENGINE_LAT = 8,
    parameter int TAG_W      = 11,
    parameter int LUMA_W     = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     q_valid,
    output logic                     q_ready,
    input  logic [TAG_W-1:0]         q_tag,
    output logic [LANES-1:0]         lane_start,
    input  logic [LANES-1:0]         eng_hit,
    input  logic [LANES*LUMA_W-1:0]  eng_luma,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic                     r_hit,
    output logic [LUMA_W-1:0]        r_luma,
    output logic [TAG_W-1:0]         r_tag,
    output logic                     busy,
    output logic [2*LANES-1:0]       dbg_lane_state
`ifdef DONUT_SCHED_STATS_EN
    ,
    output logic [15:0]              stat_stall,
    output logic [15:0]              stat_hits
`endif
);

    localparam int CNT_W = $clog2(ENGINE_LAT);
    localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ENGINE_LAT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lane_state_e;

    lane_state_e      r_state     [LANES];
    lane_state_e      w_state_nxt [LANES];
    logic [CNT_W-1:0] r_cnt       [LANES];
    logic [CNT_W-1:0] w_cnt_nxt   [LANES];
    logic [TAG_W-1:0] r_tag_slot  [LANES];
    logic             r_hit_slot  [LANES];
    logic [LUMA_W-1:0] r_luma_slot [LANES];

    logic [PTR_W-1:0] r_issue_ptr;
    logic [PTR_W-1:0] r_retire_ptr;
    logic             w_accept;
    logic             w_retire;
    logic [LANES-1:0] w_capture;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign q_ready  = !flush && (r_state[r_issue_ptr] == ST_IDLE);
    assign w_accept = q_valid && q_ready;
    assign r_valid  = (r_state[r_retire_ptr] == ST_DONE);
    // Flush wins over a retire handshake on the same edge.
    assign w_retire = r_valid && r_ready && !flush;
    assign r_hit    = r_hit_slot[r_retire_ptr];
    assign r_luma   = r_luma_slot[r_retire_ptr];
    assign r_tag    = r_tag_slot[r_retire_ptr];

    // Lane next-state, start pulses and result capture strobes.
    always_comb begin
        busy           = 1'b0;
        lane_start     = '0;
        w_capture      = '0;
        dbg_lane_state = '0;
        for (int i = 0; i < LANES; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            lane_start[i]  = w_accept && (r_issue_ptr == PTR_W'(i));
            dbg_lane_state[2*i +: 2] = r_state[i];
            if (r_state[i] != ST_IDLE) begin
                busy = 1'b1;
            end
            case (r_state[i])
                ST_IDLE: begin
                    if (lane_start[i]) begin
                        w_state_nxt[i] = ST_BUSY;
                        w_cnt_nxt[i]   = CNT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt[i] == '0) begin
                        w_state_nxt[i] = ST_DONE;
                        w_capture[i]   = !flush;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (w_retire && (r_retire_ptr == PTR_W'(i))) begin
                        w_state_nxt[i] = ST_IDLE;
                    end
                end
                default: w_state_nxt[i] = ST_IDLE;
            endcase
            if (flush) begin
                w_state_nxt[i] = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_issue_ptr  <= '0;
            r_retire_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_issue_ptr <= ptr_inc(r_issue_ptr);
            end
            if (w_retire) begin
                r_retire_ptr <= ptr_inc(r_retire_ptr);
            end
        end
    end

    // Slots survive a flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                r_tag_slot[i]  <= '0;
                r_hit_slot[i]  <= 1'b0;
                r_luma_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_start[i]) begin
                    r_tag_slot[i] <= q_tag;
                end
                if (w_capture[i]) begin
                    r_hit_slot[i]  <= eng_hit[i];
                    r_luma_slot[i] <= eng_luma[i*LUMA_W +: LUMA_W];
                end
            end
        end
    end

`ifdef DONUT_SCHED_STATS_EN
    logic [15:0] r_stat_stall;
    logic [15:0] r_stat_hits;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_stat_stall <= '0;
            r_stat_hits  <= '0;
        end else begin
            if (q_valid && !q_ready && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
            if (w_retire && r_hit) begin
                r_stat_hits <= r_stat_hits + 16'd1;
            end
        end
    end

    assign stat_stall = r_stat_stall;
    assign stat_hits  = r_stat_hits;
`endif

endmodule

// File: tb/tb_donut_query_sched.sv
module tb_donut_query_sched;
  localparam int LANES  = 2;
  localparam int LAT    = 8;
  localparam int TAG_W  = 11;
  localparam int LUMA_W = 6;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic q_valid = 1'b0;
  logic q_ready;
  logic [TAG_W-1:0] q_tag = '0;
  logic [LANES-1:0] lane_start;
  logic [LANES-1:0] eng_hit = '0;
  logic [LANES*LUMA_W-1:0] eng_luma = '0;
  logic r_valid;
  logic r_ready = 1'b0;
  logic r_hit;
  logic [LUMA_W-1:0] r_luma;
  logic [TAG_W-1:0] r_tag;
  logic busy;
  logic [2*LANES-1:0] dbg_lane_state;
`ifdef DONUT_SCHED_STATS_EN
  logic [15:0] stat_stall;
  logic [15:0] stat_hits;
`endif

  always #5 clk = ~clk;

  donut_query_sched #(
    .LANES(LANES), .ENGINE_LAT(LAT), .TAG_W(TAG_W), .LUMA_W(LUMA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .q_valid(q_valid), .q_ready(q_ready), .q_tag(q_tag),
    .lane_start(lane_start), .eng_hit(eng_hit), .eng_luma(eng_luma),
    .r_valid(r_valid), .r_ready(r_ready), .r_hit(r_hit),
    .r_luma(r_luma), .r_tag(r_tag), .busy(busy),
    .dbg_lane_state(dbg_lane_state)
`ifdef DONUT_SCHED_STATS_EN
    , .stat_stall(stat_stall), .stat_hits(stat_hits)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  // One entry per accepted query, oldest first; a query occupies its lane
  // until it leaves this queue.
  typedef struct {
    logic [TAG_W-1:0]  tag;
    int                lane;
    int                cap_cyc;
    logic              hit;
    logic [LUMA_W-1:0] luma;
  } ent_t;

  ent_t exp_q[$];
  logic [TAG_W-1:0] ret_log[$];
  int m_issue = 0;
  int cyc = 0;
  logic [15:0] m_stall = '0;
  logic [15:0] m_hits = '0;

  int n_cmp = 0;
  int n_fail = 0;

  logic t_acc;
  int t_acc_cyc;
  logic [LANES-1:0] t_ls;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: compare outputs against the model, advance the model
  // by the edge that ends this cycle, then move to the next falling edge.
  task automatic tick();
    logic occ, e_qr, e_acc, e_rv;
    logic [LANES-1:0] e_ls;
    ent_t e;
    #1;
    t_acc = 1'b0;
    t_ls = lane_start;
    if (rst_n) begin
      occ = 1'b0;
      foreach (exp_q[k]) if (exp_q[k].lane == m_issue) occ = 1'b1;
      e_qr  = !flush && !occ;
      e_acc = q_valid && e_qr;
      e_ls  = '0;
      if (e_acc) e_ls[m_issue] = 1'b1;
      e_rv  = (exp_q.size() > 0) && (cyc > exp_q[0].cap_cyc);

      check("q_ready", 32'(q_ready), 32'(e_qr));
      check("lane_start", 32'(lane_start), 32'(e_ls));
      check("r_valid", 32'(r_valid), 32'(e_rv));
      check("busy", 32'(busy), 32'(exp_q.size() > 0));
      if (e_rv) begin
        check("r_tag", 32'(r_tag), 32'(exp_q[0].tag));
        check("r_hit", 32'(r_hit), 32'(exp_q[0].hit));
        check("r_luma", 32'(r_luma), 32'(exp_q[0].luma));
      end
`ifdef DONUT_SCHED_STATS_EN
      check("stat_stall", 32'(stat_stall), 32'(m_stall));
      check("stat_hits", 32'(stat_hits), 32'(m_hits));
`endif

      if (flush) begin
        exp_q.delete();
        m_issue = 0;
        m_stall = '0;
        m_hits  = '0;
      end else begin
        foreach (exp_q[k]) begin
          if (exp_q[k].cap_cyc == cyc) begin
            e = exp_q[k];
            e.hit  = eng_hit[e.lane];
            e.luma = eng_luma[e.lane*LUMA_W +: LUMA_W];
            exp_q[k] = e;
          end
        end
        if (e_rv && r_ready) begin
          if (exp_q[0].hit) m_hits = m_hits + 16'd1;
          ret_log.push_back(exp_q[0].tag);
          void'(exp_q.pop_front());
        end
        if (q_valid && !e_qr && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (e_acc) begin
          e.tag = q_tag;
          e.lane = m_issue;
          e.cap_cyc = cyc + LAT;
          e.hit = 1'b0;
          e.luma = '0;
          exp_q.push_back(e);
          m_issue = (m_issue + 1) % LANES;
          t_acc_cyc = cyc;
        end
      end
      t_acc = e_acc;
    end else begin
      exp_q.delete();
      m_issue = 0;
      m_stall = '0;
      m_hits  = '0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [TAG_W-1:0] tag, output int acc_cyc, output logic [LANES-1:0] ls);
    bit done;
    done = 0;
    acc_cyc = -1;
    ls = '0;
    q_tag = tag;
    q_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      if (t_acc) begin
        done = 1;
        acc_cyc = t_acc_cyc;
        ls = t_ls;
      end
    end
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain();
    r_ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a1, a2, a3, n;
    logic [LANES-1:0] ls;
    bit seen;

    @(negedge clk);
    repeat (3) tick();
    check("rst_lane_start", 32'(lane_start), 32'd0);
    check("rst_r_valid", 32'(r_valid), 32'd0);
    check("rst_r_hit", 32'(r_hit), 32'd0);
    check("rst_r_luma", 32'(r_luma), 32'd0);
    check("rst_r_tag", 32'(r_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_q_ready", 32'(q_ready), 32'd1);
    check("rst_busy_rel", 32'(busy), 32'd0);

    // Single query: tag 0x155, lane 0 engine reports hit, luma 0x2A.
    eng_hit = 2'b01;
    eng_luma = {6'h15, 6'h2A};
    r_ready = 1'b1;
    q_tag = 11'h155;
    q_valid = 1'b1;
    #1;
    check("single_lane_start", 32'(lane_start), 32'b01);
    tick();
    q_valid = 1'b0;
    #1;
    check("single_start_once", 32'(lane_start), 32'd0);
    n = 0;
    while (!r_valid && n < 50) begin
      tick();
      n++;
    end
    check("single_latency", 32'(n), 32'd8);
    check("single_r_hit", 32'(r_hit), 32'd1);
    check("single_r_luma", 32'(r_luma), 32'h2A);
    check("single_r_tag", 32'(r_tag), 32'h155);
    tick();
    check("single_valid_once", 32'(r_valid), 32'd0);

    // Back-to-back tags 1, 2, 3 with q_valid held high.
    do_flush();
    ret_log.delete();
    send(11'd1, a1, ls);
    check("b2b_lane_t1", 32'(ls), 32'b01);
    send(11'd2, a2, ls);
    check("b2b_lane_t2", 32'(ls), 32'b10);
    send(11'd3, a3, ls);
    check("b2b_lane_t3", 32'(ls), 32'b01);
    q_valid = 1'b0;
    check("b2b_consecutive", 32'(a2 - a1), 32'd1);
    check("b2b_turnaround", 32'(a3 - a1), 32'd10);
    drain();
    check("b2b_count", 32'(ret_log.size()), 32'd3);
    if (ret_log.size() == 3) begin
      check("b2b_order0", 32'(ret_log[0]), 32'd1);
      check("b2b_order1", 32'(ret_log[1]), 32'd2);
      check("b2b_order2", 32'(ret_log[2]), 32'd3);
    end

    // Consumer stall for 20 cycles with both lanes holding results.
    do_flush();
    r_ready = 1'b0;
    eng_hit = 2'b10;
    eng_luma = {6'h33, 6'h0C};
    send(11'h0A, a1, ls);
    send(11'h0B, a2, ls);
    q_valid = 1'b0;
    repeat (20) tick();
    check("stall_q_ready", 32'(q_ready), 32'd0);
    check("stall_r_valid", 32'(r_valid), 32'd1);
    check("stall_r_tag", 32'(r_tag), 32'h0A);
    check("stall_r_luma", 32'(r_luma), 32'h0C);
    r_ready = 1'b1;
    tick();
    check("stall_second_valid", 32'(r_valid), 32'd1);
    check("stall_second_tag", 32'(r_tag), 32'h0B);
    check("stall_second_hit", 32'(r_hit), 32'd1);
    tick();
    check("stall_drained", 32'(r_valid), 32'd0);

    // Flush at E4 of an in-flight query.
    do_flush();
    send(11'h77, a1, ls);
    q_valid = 1'b0;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_r_valid", 32'(r_valid), 32'd0);
    seen = 0;
    repeat (15) begin
      if (r_valid) seen = 1;
      tick();
    end
    check("flush_no_result", 32'(seen), 32'd0);
    send(11'h78, a1, ls);
    q_valid = 1'b0;
    check("flush_next_lane0", 32'(ls), 32'b01);
    drain();

    // Randomized traffic against the model.
    for (int blk = 0; blk < 30; blk++) begin
      int rp;
      rp = $urandom_range(20, 100);
      for (int k = 0; k < 100; k++) begin
        flush    = ($urandom_range(0, 99) < 2);
        q_valid  = ($urandom_range(0, 9) < 7);
        q_tag    = TAG_W'($urandom);
        r_ready  = ($urandom_range(1, 100) <= rp);
        eng_hit  = LANES'($urandom);
        eng_luma = (LANES*LUMA_W)'($urandom);
        tick();
      end
    end
    flush = 1'b0;
    q_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
